// File: rtl/decode_pkg.sv
// Shared types and encodings for the decode/issue front end.
package decode_pkg;

    typedef enum logic [2:0] {
        ALU_LOADSTORE = 3'b000,
        ALU_RTYPE     = 3'b001,
        ALU_ITYPE     = 3'b010,
        ALU_BRANCH    = 3'b011,
        ALU_LUI       = 3'b100,
        ALU_JALR      = 3'b101,
        ALU_NONE      = 3'b111
    } alu_op_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    typedef struct packed {
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic        alu_src;
        logic        branch;
        logic        jump;
        logic        mem_read;
        logic        mem_write;
        logic        reg_write;
        logic        mem_to_reg;
        alu_op_t     alu_op;
    } decoded_t;

endpackage

// File: rtl/decode.sv
// Combinational RV32I instruction decode into the control/operand bundle.
module decode
    import decode_pkg::*;
(
    input  logic [31:0] inst,
    output decoded_t    dec
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign opcode = inst[6:0];
    assign funct3 = inst[14:12];
    assign imm_i  = {{20{inst[31]}}, inst[31:20]};
    assign imm_s  = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    assign imm_b  = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    assign imm_u  = {inst[31:12], 12'h000};
    assign imm_j  = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

    always_comb begin
        dec        = '0;
        dec.rs1    = inst[19:15];
        dec.rs2    = inst[24:20];
        dec.rd     = inst[11:7];
        dec.alu_op = ALU_NONE;
        case (opcode)
            OP_LOAD: begin
                dec.imm = imm_i;  dec.alu_src = 1'b1; dec.mem_read = 1'b1;
                dec.reg_write = 1'b1; dec.mem_to_reg = 1'b1; dec.alu_op = ALU_LOADSTORE;
            end
            OP_STORE: begin
                dec.imm = imm_s;  dec.alu_src = 1'b1; dec.mem_write = 1'b1;
                dec.alu_op = ALU_LOADSTORE;
            end
            OP_REG: begin
                dec.reg_write = 1'b1; dec.alu_op = ALU_RTYPE;
            end
            OP_IMM: begin
                // shift-immediates carry a zero-extended shamt, not a signed immediate
                dec.imm = (funct3 == 3'b001 || funct3 == 3'b101) ? {27'h0, inst[24:20]} : imm_i;
                dec.alu_src = 1'b1; dec.reg_write = 1'b1; dec.alu_op = ALU_ITYPE;
            end
            OP_BRANCH: begin
                dec.imm = imm_b;  dec.branch = 1'b1; dec.alu_op = ALU_BRANCH;
            end
            OP_LUI: begin
                dec.imm = imm_u;  dec.alu_src = 1'b1; dec.reg_write = 1'b1; dec.alu_op = ALU_LUI;
            end
            OP_JAL: begin
                dec.imm = imm_j;  dec.jump = 1'b1; dec.reg_write = 1'b1; dec.alu_op = ALU_NONE;
            end
            OP_JALR: begin
                dec.imm = imm_i;  dec.jump = 1'b1; dec.alu_src = 1'b1; dec.reg_write = 1'b1;
                dec.alu_op = ALU_JALR;
            end
            default: dec.alu_op = ALU_NONE;
        endcase
    end

endmodule

// File: rtl/inst_fifo.sv
// Small pointer-based FIFO; pointers carry one wrap bit so no occupancy counter is needed.
module inst_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wptr, rptr;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) wptr <= wptr + (AW+1)'(1);
            if (pop)  rptr <= rptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wptr[AW-1:0]] <= wdata;
    end

    assign rdata = mem[rptr[AW-1:0]];
    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);

endmodule

// File: rtl/decode_issue_ctrl.sv
// Fetch-to-dispatch issue stage: buffers fetch, decodes the head, registers a valid/ready bundle
// and throttles control-flow issue against the unresolved-branch budget.
module decode_issue_ctrl
    import decode_pkg::*;
#(
    parameter int DEPTH  = 2,
    parameter int MAX_BR = 4,
    parameter int BRW    = 3
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           flush,
    input  logic           if_valid,
    output logic           if_ready,
    input  logic [31:0]    if_inst,
    input  logic [31:0]    if_pc,
    output logic           id_valid,
    input  logic           id_ready,
    output logic [31:0]    id_pc,
    output logic [4:0]     id_rs1,
    output logic [4:0]     id_rs2,
    output logic [4:0]     id_rd,
    output logic [31:0]    id_imm,
    output logic           id_ALUSrc,
    output logic           id_branch,
    output logic           id_jump,
    output logic           id_MemRead,
    output logic           id_MemWrite,
    output logic           id_RegWrite,
    output logic           id_MemToReg,
    output logic [2:0]     id_ALUOp,
    input  logic           br_resolve,
    output logic [BRW-1:0] br_inflight
);

    logic        fifo_full, fifo_empty, push, pop;
    logic        head_bubble, head_ctl, br_stall, load_en, br_inc, br_dec;
    logic [63:0] head;
    decoded_t    head_dec, id_q;

    assign if_ready = !fifo_full;
    assign push     = if_valid && !fifo_full && !flush;

    inst_fifo #(.DEPTH(DEPTH), .W(64)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .push  (push),
        .pop   (pop),
        .wdata ({if_pc, if_inst}),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    decode u_decode (
        .inst (head[31:0]),
        .dec  (head_dec)
    );

    assign head_bubble = (head[31:0] == 32'h0);
    assign head_ctl    = head_dec.branch | head_dec.jump;
    // budget is judged on the registered count, so a same-cycle resolve unblocks only next cycle
    assign br_stall    = head_ctl && (br_inflight == BRW'(MAX_BR));
    assign load_en     = (!id_valid || id_ready) && !fifo_empty && !head_bubble && !br_stall && !flush;
    assign pop         = !fifo_empty && !flush && (head_bubble || load_en);
    assign br_inc      = load_en && head_ctl;
    assign br_dec      = br_resolve && (br_inflight != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            id_valid <= 1'b0;
            id_pc    <= '0;
            id_q     <= '0;
        end else if (flush) begin
            id_valid <= 1'b0;
        end else if (load_en) begin
            id_valid <= 1'b1;
            id_pc    <= head[63:32];
            id_q     <= head_dec;
        end else if (id_ready) begin
            id_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush)
            br_inflight <= '0;
        else if (br_inc && !br_dec)
            br_inflight <= br_inflight + BRW'(1);
        else if (br_dec && !br_inc)
            br_inflight <= br_inflight - BRW'(1);
    end

    assign id_rs1      = id_q.rs1;
    assign id_rs2      = id_q.rs2;
    assign id_rd       = id_q.rd;
    assign id_imm      = id_q.imm;
    assign id_ALUSrc   = id_q.alu_src;
    assign id_branch   = id_q.branch;
    assign id_jump     = id_q.jump;
    assign id_MemRead  = id_q.mem_read;
    assign id_MemWrite = id_q.mem_write;
    assign id_RegWrite = id_q.reg_write;
    assign id_MemToReg = id_q.mem_to_reg;
    assign id_ALUOp    = id_q.alu_op;

endmodule

// File: tb/tb_decode_issue_ctrl.sv
// Scoreboard bench for decode_issue_ctrl: directed scenarios followed by randomized traffic.
module tb_decode_issue_ctrl;

    localparam int MAX_BR = 2;
    localparam int BRW    = 2;

    logic clk, reset, flush, if_valid, if_ready, id_valid, id_ready, br_resolve;
    logic [31:0] if_inst, if_pc, id_pc, id_imm;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic        id_ALUSrc, id_branch, id_jump, id_MemRead, id_MemWrite, id_RegWrite, id_MemToReg;
    logic [2:0]  id_ALUOp;
    logic [BRW-1:0] br_inflight;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] imm;
        logic        alusrc, branch, jump, memread, memwrite, regwrite, memtoreg;
        logic [2:0]  aluop;
    } exp_t;

    exp_t act, prev_act;
    exp_t sb[$];
    int checks = 0, errors = 0, hs_count = 0, br_model = 0;
    logic prev_valid = 0, prev_hs = 0, prev_flush = 0, prev_resolve = 0, prev_hold = 0;

    assign act = {id_pc, id_rs1, id_rs2, id_rd, id_imm, id_ALUSrc, id_branch, id_jump,
                  id_MemRead, id_MemWrite, id_RegWrite, id_MemToReg, id_ALUOp};

    decode_issue_ctrl #(.DEPTH(2), .MAX_BR(MAX_BR), .BRW(BRW)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .if_valid(if_valid), .if_ready(if_ready), .if_inst(if_inst), .if_pc(if_pc),
        .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_imm(id_imm),
        .id_ALUSrc(id_ALUSrc), .id_branch(id_branch), .id_jump(id_jump),
        .id_MemRead(id_MemRead), .id_MemWrite(id_MemWrite), .id_RegWrite(id_RegWrite),
        .id_MemToReg(id_MemToReg), .id_ALUOp(id_ALUOp),
        .br_resolve(br_resolve), .br_inflight(br_inflight)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    // Reference decode built from the ISA field layout with plain shifts and masks.
    function automatic exp_t ref_decode(input logic [31:0] w, input logic [31:0] pc);
        exp_t e;
        logic signed [31:0] sw;
        logic [31:0] s20, s25, s31;
        int op, f3;
        sw  = w;
        s20 = sw >>> 20;
        s25 = sw >>> 25;
        s31 = sw >>> 31;
        op  = int'(w & 32'h7F);
        f3  = int'((w >> 12) & 32'h7);
        e       = '0;
        e.pc    = pc;
        e.rd    = 5'((w >> 7) & 32'h1F);
        e.rs1   = 5'((w >> 15) & 32'h1F);
        e.rs2   = 5'((w >> 20) & 32'h1F);
        e.aluop = 3'd7;
        case (op)
            'h03: begin e.aluop = 3'd0; e.alusrc = 1; e.memread = 1; e.regwrite = 1; e.memtoreg = 1; e.imm = s20; end
            'h23: begin e.aluop = 3'd0; e.alusrc = 1; e.memwrite = 1; e.imm = (s25 << 5) | ((w >> 7) & 32'h1F); end
            'h33: begin e.aluop = 3'd1; e.regwrite = 1; end
            'h13: begin
                e.aluop = 3'd2; e.alusrc = 1; e.regwrite = 1;
                e.imm = (f3 == 1 || f3 == 5) ? ((w >> 20) & 32'h1F) : s20;
            end
            'h63: begin
                e.aluop = 3'd3; e.branch = 1;
                e.imm = (s31 << 12) | (((w >> 7) & 32'h1) << 11) | (((w >> 25) & 32'h3F) << 5) | (((w >> 8) & 32'hF) << 1);
            end
            'h37: begin e.aluop = 3'd4; e.alusrc = 1; e.regwrite = 1; e.imm = w & 32'hFFFFF000; end
            'h6F: begin
                e.aluop = 3'd7; e.jump = 1; e.regwrite = 1;
                e.imm = (s31 << 20) | (((w >> 12) & 32'hFF) << 12) | (((w >> 20) & 32'h1) << 11) | (((w >> 21) & 32'h3FF) << 1);
            end
            'h67: begin e.aluop = 3'd5; e.jump = 1; e.alusrc = 1; e.regwrite = 1; e.imm = s20; end
            default: ;
        endcase
        return e;
    endfunction

    // Monitor: tracks accepted fetches, checks every handshake, models the branch budget.
    always @(negedge clk) begin
        logic new_load;
        int   nctl;
        if (reset) begin
            sb.delete();
            br_model = 0; prev_valid = 0; prev_hs = 0; prev_flush = 0; prev_resolve = 0; prev_hold = 0;
        end else begin
            nctl = 0;
            new_load = id_valid && (prev_hs || !prev_valid);
            if (new_load) begin
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL spurious_bundle: got pc=%h with nothing expected", id_pc);
                end else if (sb[0].branch || sb[0].jump) nctl = 1;
            end
            if (prev_flush) br_model = 0;
            else br_model = br_model + nctl - ((prev_resolve && br_model > 0) ? 1 : 0);
            checks++;
            if (int'(br_inflight) != br_model) begin
                errors++;
                $display("FAIL br_inflight: got %0d expected %0d", br_inflight, br_model);
            end
            if (prev_hold) begin
                checks++;
                if (!id_valid || act !== prev_act) begin
                    errors++;
                    $display("FAIL hold_stable: got valid=%b %h expected valid=1 %h", id_valid, act, prev_act);
                end
            end
            if (id_valid && id_ready) begin
                hs_count++;
                if (sb.size() > 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    checks++;
                    if (act !== e) begin
                        errors++;
                        $display("FAIL bundle pc=%h: got %h expected %h", e.pc, act, e);
                    end
                end
            end
            if (flush) sb.delete();
            else if (if_valid && if_ready && if_inst != 32'h0) sb.push_back(ref_decode(if_inst, if_pc));
            prev_hs = id_valid && id_ready; prev_valid = id_valid; prev_flush = flush;
            prev_resolve = br_resolve; prev_hold = id_valid && !id_ready && !flush; prev_act = act;
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Offer one word and hold it until the stage takes it (bounded).
    task automatic send(input logic [31:0] w, input logic [31:0] pc);
        logic ok;
        if_valid = 1; if_inst = w; if_pc = pc;
        for (int n = 0; n < 30; n++) begin
            ok = if_ready && !flush;
            cyc(1);
            if (ok) begin
                if_valid = 0;
                return;
            end
        end
        if_valid = 0;
        checks++; errors++;
        $display("FAIL send_timeout: pc=%h not accepted", pc);
    endtask

    localparam logic [31:0] ADDI = 32'h09A00293, LW = 32'h0200A583, SW = 32'h00732623;
    localparam logic [31:0] AND_ = 32'h007474B3, SUB = 32'h40638433, BNE = 32'hFE009CE3;
    localparam logic [31:0] SRA = 32'h405353B3;

    initial begin
        logic [6:0]  ops [8];
        logic [31:0] w, pc;
        int hs0;
        ops = '{7'h03, 7'h23, 7'h33, 7'h13, 7'h63, 7'h37, 7'h6F, 7'h67};
        reset = 1; flush = 0; if_valid = 0; if_inst = 0; if_pc = 0; id_ready = 1; br_resolve = 0;
        cyc(3);
        reset = 0;
        chk("reset_id_valid", 32'(id_valid), 0);
        chk("reset_if_ready", 32'(if_ready), 1);
        chk("reset_br", 32'(br_inflight), 0);
        chk("reset_pc_imm", id_pc | id_imm, 0);

        // single ADDI: one cycle in the FIFO, then on the output
        if_valid = 1; if_inst = ADDI; if_pc = 32'h100;
        cyc(1); if_valid = 0;
        chk("latency_not_early", 32'(id_valid), 0);
        cyc(1);
        chk("addi_valid", 32'(id_valid), 1);
        chk("addi_rd", 32'(id_rd), 5);
        chk("addi_imm", id_imm, 154);
        chk("addi_aluop", 32'(id_ALUOp), 2);
        chk("addi_pc", id_pc, 32'h100);
        cyc(2);

        // back-pressure: output plus two FIFO slots fill, then drain one per cycle
        id_ready = 0;
        send(LW, 32'h200); send(SW, 32'h204); send(AND_, 32'h208);
        chk("bp_if_ready_low", 32'(if_ready), 0);
        cyc(2);
        chk("bp_hold_rd", 32'(id_rd), 11);
        chk("bp_hold_imm", id_imm, 32);
        chk("bp_hold_memread", 32'(id_MemRead), 1);
        chk("bp_hold_pc", id_pc, 32'h200);
        hs0 = hs_count;
        id_ready = 1; if_valid = 1; if_inst = SUB; if_pc = 32'h20C;
        cyc(2); if_valid = 0;
        cyc(2);
        chk("bp_drain_rate", 32'(hs_count - hs0), 4);
        cyc(2);

        // branch budget of 2
        send(BNE, 32'h300); send(BNE, 32'h304); send(BNE, 32'h308);
        cyc(3);
        chk("br_full_count", 32'(br_inflight), 2);
        chk("br_third_held", 32'(id_valid), 0);
        br_resolve = 1; cyc(1); br_resolve = 0;
        chk("br_after_resolve", 32'(br_inflight), 1);
        chk("br_not_same_cycle", 32'(id_valid), 0);
        cyc(1);
        chk("br_third_issued", 32'(id_valid), 1);
        chk("br_third_imm", id_imm, 32'hFFFFFFF8);
        chk("br_third_pc", id_pc, 32'h308);
        chk("br_count_back", 32'(br_inflight), 2);
        br_resolve = 1; cyc(3); br_resolve = 0;
        chk("br_saturate_zero", 32'(br_inflight), 0);

        // bubble in the middle is dropped
        hs0 = hs_count;
        send(ADDI, 32'h400); send(32'h0, 32'h404); send(SRA, 32'h408);
        cyc(4);
        chk("bubble_two_bundles", 32'(hs_count - hs0), 2);

        // flush with coincident fetch and resolve
        send(BNE, 32'h500);
        cyc(2);
        id_ready = 0;
        send(ADDI, 32'h504); send(SRA, 32'h508); send(LW, 32'h50C);
        chk("pre_flush_br", 32'(br_inflight), 1);
        flush = 1; if_valid = 1; if_inst = SW; if_pc = 32'h510; br_resolve = 1;
        cyc(1);
        flush = 0; if_valid = 0; br_resolve = 0;
        chk("flush_id_valid", 32'(id_valid), 0);
        chk("flush_br", 32'(br_inflight), 0);
        chk("flush_if_ready", 32'(if_ready), 1);
        id_ready = 1;
        cyc(3);
        chk("flush_nothing_out", 32'(id_valid), 0);

        // reset in the middle of traffic
        id_ready = 0;
        send(ADDI, 32'h600); send(SRA, 32'h604);
        chk("pre_reset_valid", 32'(id_valid), 1);
        reset = 1; cyc(1); reset = 0;
        chk("midrst_valid", 32'(id_valid), 0);
        chk("midrst_data", id_pc | id_imm | 32'(id_rd) | 32'(id_ALUOp) | 32'(id_RegWrite), 0);
        chk("midrst_br", 32'(br_inflight), 0);
        chk("midrst_if_ready", 32'(if_ready), 1);

        // randomized traffic
        pc = 32'h1000;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 8) == 0) w = 32'h0;
            else begin
                w = $urandom;
                w[6:0] = ops[$urandom_range(0, 7)];
            end
            if_valid   = ($urandom_range(0, 3) != 0);
            if_inst    = w;
            if_pc      = pc;
            id_ready   = ($urandom_range(0, 3) != 0);
            br_resolve = ($urandom_range(0, 2) == 0);
            flush      = ($urandom_range(0, 49) == 0);
            pc = pc + 4;
            cyc(1);
        end
        if_valid = 0; flush = 0; id_ready = 1; br_resolve = 1;
        cyc(12);
        br_resolve = 0;
        cyc(1);
        chk("drain_scoreboard_empty", 32'(sb.size()), 0);
        chk("drain_br_zero", 32'(br_inflight), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
